// File: rtl/load_store_unit.sv
// Load/store unit: accepts one RV32I memory request at a time and sequences
// it through the data RAM (single read, single write, or read-modify-write
// for sub-word stores), then returns a one-cycle writeback pulse.
// Optional feature: define LSU_MISALIGN_TRAP_EN to trap misaligned half/word
// accesses (no RAM access, misalignErr pulsed with the response).
//
// state | meaning
// IDLE  | ready for a new request
// READ  | RAM read enable asserted, read word registered at end of cycle
// WRITE | RAM write enable asserted with the full (possibly merged) word
// RESP  | wbValid pulse, writeback data presented
module load_store_unit #(
  parameter logic DataCacheReadAccept  = 1'b1,
  parameter logic DataCacheWriteAccept = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqWrite,
  input  logic [2:0]  reqFunct3,
  input  logic [31:0] reqAddr,
  input  logic [31:0] reqWdata,
  input  logic [4:0]  reqRd,
  output logic        dataCacheReadEnable,
  output logic        dataCacheWriteEnable,
  output logic [31:0] addr,
  output logic [31:0] dataWrite,
  input  logic [31:0] dataRead,
  output logic        wbValid,
  output logic [4:0]  wbRd,
  output logic [31:0] wbData,
  output logic        stall,
  output logic        misalignErr
);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, RESP = 2'd3} state_t;

  state_t      state, state_next;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [2:0]  funct3_q;
  logic        write_q;
  logic [4:0]  rd_q;
  logic        noop_q, mis_q;
  logic        accept, supported, misaligned;
  logic        rd_active, wr_active, load_result;
  logic [31:0] load_val, merge_val;

  assign accept = reqValid && (state == IDLE);

  // Stores only support SB/SH/SW; loads reject 011/110/111.
  assign supported = reqWrite ? (reqFunct3 <= 3'b010)
                              : ((reqFunct3 != 3'b011) && (reqFunct3[2:1] != 2'b11));

`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned = ((reqFunct3[1:0] == 2'b01) && reqAddr[0]) ||
                      ((reqFunct3 == 3'b010) && (reqAddr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state sequencing; only SW skips the read phase among stores.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!supported || misaligned)             state_next = RESP;
          else if (!reqWrite || reqFunct3 != 3'b010) state_next = READ;
          else                                       state_next = WRITE;
        end
      end
      READ:    state_next = write_q ? WRITE : RESP;
      WRITE:   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request latch on acceptance and read-word capture in READ.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      funct3_q <= '0;
      write_q  <= 1'b0;
      rd_q     <= '0;
      noop_q   <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      if (accept) begin
        addr_q   <= reqAddr;
        wdata_q  <= reqWdata;
        funct3_q <= reqFunct3;
        write_q  <= reqWrite;
        rd_q     <= reqRd;
        noop_q   <= !supported || misaligned;
        mis_q    <= supported && misaligned;
      end
      if (state == READ) rdata_q <= dataRead;
    end
  end

  // Load lane extraction; half accesses look only at addr bit 1.
  always_comb begin
    load_val = rdata_q;
    case (funct3_q)
      3'b000:  load_val = {{24{rdata_q[{addr_q[1:0], 3'b000} + 7]}}, rdata_q[{addr_q[1:0], 3'b000} +: 8]};
      3'b100:  load_val = {24'h0, rdata_q[{addr_q[1:0], 3'b000} +: 8]};
      3'b001:  load_val = {{16{rdata_q[{addr_q[1], 4'b0000} + 15]}}, rdata_q[{addr_q[1], 4'b0000} +: 16]};
      3'b101:  load_val = {16'h0, rdata_q[{addr_q[1], 4'b0000} +: 16]};
      default: load_val = rdata_q;
    endcase
  end

  // Store word: sub-word stores patch the registered read word.
  always_comb begin
    merge_val = rdata_q;
    case (funct3_q[1:0])
      2'b00:   merge_val[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01:   merge_val[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merge_val = wdata_q;
    endcase
  end

  // Reset gates the enables so an interrupted WRITE never reaches the RAM.
  assign rd_active = (state == READ)  && !rst;
  assign wr_active = (state == WRITE) && !rst;

  assign dataCacheReadEnable  = rd_active ? DataCacheReadAccept  : ~DataCacheReadAccept;
  assign dataCacheWriteEnable = wr_active ? DataCacheWriteAccept : ~DataCacheWriteAccept;
  assign addr                 = {2'b00, addr_q[31:2]};
  assign dataWrite            = merge_val;

  assign reqReady    = (state == IDLE);
  assign stall       = (state != IDLE);
  assign wbValid     = (state == RESP);
  assign load_result = (state == RESP) && !write_q && !noop_q;
  assign wbRd        = load_result ? rd_q : 5'd0;
  assign wbData      = load_result ? load_val : 32'd0;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalignErr = (state == RESP) && mis_q;
`else
  assign misalignErr = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized
// loads/stores checked against a word-array memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        reqValid, reqReady, reqWrite;
  logic [2:0]  reqFunct3;
  logic [31:0] reqAddr, reqWdata;
  logic [4:0]  reqRd;
  logic        dataCacheReadEnable, dataCacheWriteEnable;
  logic [31:0] addr, dataWrite, dataRead;
  logic        wbValid;
  logic [4:0]  wbRd;
  logic [31:0] wbData;
  logic        stall, misalignErr;

  int checks = 0;
  int errors = 0;

  logic [31:0] ram      [0:63];
  logic [31:0] init_img [0:63];
  logic [31:0] mdl      [0:63];
  logic        ram_load;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .rst(rst),
    .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
    .reqFunct3(reqFunct3), .reqAddr(reqAddr), .reqWdata(reqWdata), .reqRd(reqRd),
    .dataCacheReadEnable(dataCacheReadEnable), .dataCacheWriteEnable(dataCacheWriteEnable),
    .addr(addr), .dataWrite(dataWrite), .dataRead(dataRead),
    .wbValid(wbValid), .wbRd(wbRd), .wbData(wbData),
    .stall(stall), .misalignErr(misalignErr)
  );

  // Data RAM: combinational read, write on rising edge when enabled.
  assign dataRead = ram[addr[5:0]];
  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < 64; i++) ram[i] <= init_img[i];
    end else if (dataCacheWriteEnable === 1'b1) begin
      ram[addr[5:0]] <= dataWrite;
    end
  end

  // ---------------- reference model ----------------
  function automatic logic ref_supported(input logic w, input logic [2:0] f);
    if (w) return (f == 3'd0 || f == 3'd1 || f == 3'd2);
    return (f == 3'd0 || f == 3'd1 || f == 3'd2 || f == 3'd4 || f == 3'd5);
  endfunction

  function automatic logic ref_misaligned(input logic [2:0] f, input logic [31:0] a);
    logic m;
    m = ((f == 3'd1 || f == 3'd5) && (a % 2 != 0)) || (f == 3'd2 && (a % 4 != 0));
`ifndef LSU_MISALIGN_TRAP_EN
    m = 1'b0;
`endif
    return m;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [2:0] f,
                                           input logic [31:0] a);
    logic [31:0] v, sh_b, sh_h;
    sh_b = (a % 4) * 8;
    sh_h = ((a % 4) >= 2) ? 32'd16 : 32'd0;
    case (f)
      3'd0: begin v = (word >> sh_b) % 256;   if (v >= 128)   v = v + 32'hFFFF_FF00; end
      3'd4: v = (word >> sh_b) % 256;
      3'd1: begin v = (word >> sh_h) % 65536; if (v >= 32768) v = v + 32'hFFFF_0000; end
      3'd5: v = (word >> sh_h) % 65536;
      default: v = word;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [2:0] f,
                                            input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] mask, sh_b, sh_h;
    sh_b = (a % 4) * 8;
    sh_h = ((a % 4) >= 2) ? 32'd16 : 32'd0;
    case (f)
      3'd0: begin mask = 32'hFF << sh_b;   return (old & ~mask) | ((wd % 256) << sh_b); end
      3'd1: begin mask = 32'hFFFF << sh_h; return (old & ~mask) | ((wd % 65536) << sh_h); end
      default: return wd;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  // Issue one request, scramble the inputs after acceptance, and record what
  // the DUT does until the writeback pulse (lat = 0 if it never comes).
  task automatic do_req(input logic w, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] wd, input logic [4:0] rd,
                        output int lat, output logic ready_pre, output logic busy_ok,
                        output int n_re, output int n_we, output logic [31:0] we_addr,
                        output logic [31:0] we_data, output logic [4:0] wb_rd,
                        output logic [31:0] wb_data, output logic mis);
    logic got;
    @(negedge clk);
    reqValid = 1'b1; reqWrite = w; reqFunct3 = f; reqAddr = a; reqWdata = wd; reqRd = rd;
    ready_pre = reqReady;
    @(posedge clk); #1;
    reqValid = 1'($urandom % 2); reqWrite = 1'($urandom % 2); reqFunct3 = 3'($urandom);
    reqAddr = $urandom; reqWdata = $urandom; reqRd = 5'($urandom);
    lat = 0; got = 1'b0; busy_ok = 1'b1; n_re = 0; n_we = 0;
    we_addr = '0; we_data = '0; wb_rd = '0; wb_data = '0; mis = 1'b0;
    for (int c = 1; c <= 8 && !got; c++) begin
      @(negedge clk);
      if (reqReady !== 1'b0 || stall !== 1'b1) busy_ok = 1'b0;
      if (dataCacheReadEnable === 1'b1) n_re++;
      if (dataCacheWriteEnable === 1'b1) begin n_we++; we_addr = addr; we_data = dataWrite; end
      if (wbValid === 1'b1) begin
        got = 1'b1; lat = c; wb_rd = wbRd; wb_data = wbData; mis = misalignErr;
      end
    end
    reqValid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1; ram_load = 1'b1; reqValid = 1'b0; reqWrite = 1'b0; reqFunct3 = '0;
    reqAddr = '0; reqWdata = '0; reqRd = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (dataCacheReadEnable !== 1'b0 || dataCacheWriteEnable !== 1'b0) begin
      errors++; $display("FAIL reset_enables got re=%0b we=%0b want 0 0", dataCacheReadEnable, dataCacheWriteEnable);
    end
    rst = 1'b0; ram_load = 1'b0;
    @(negedge clk);
    checks++;
    if (reqReady !== 1'b1 || stall !== 1'b0) begin
      errors++; $display("FAIL reset_ready got ready=%0b stall=%0b want 1 0", reqReady, stall);
    end
    checks++;
    if (wbValid !== 1'b0 || wbRd !== 5'd0 || wbData !== 32'd0 || misalignErr !== 1'b0) begin
      errors++; $display("FAIL reset_outputs got v=%0b rd=%0d d=%h mis=%0b want all 0", wbValid, wbRd, wbData, misalignErr);
    end
  endtask

  task automatic test_loads;
    logic [2:0]  f_t   [4] = '{3'd0, 3'd4, 3'd1, 3'd5};
    logic [31:0] a_t   [4] = '{32'h11, 32'h11, 32'h12, 32'h12};
    logic [31:0] exp_t [4] = '{32'hFFFF_FFAA, 32'h0000_00AA, 32'hFFFF_8899, 32'h0000_8899};
    int lat, n_re, n_we; logic rdy, busy, mis; logic [31:0] wa, wdv, d; logic [4:0] r;
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, f_t[i], a_t[i], 32'h0, 5'd5 + 5'(i), lat, rdy, busy, n_re, n_we, wa, wdv, r, d, mis);
      checks++;
      if (lat != 2 || n_re != 1 || n_we != 0 || !rdy || !busy) begin
        errors++; $display("FAIL load_seq[%0d] got lat=%0d re=%0d we=%0d rdy=%0b busy=%0b want 2 1 0 1 1", i, lat, n_re, n_we, rdy, busy);
      end
      checks++;
      if (r !== 5'd5 + 5'(i) || d !== exp_t[i]) begin
        errors++; $display("FAIL load_data[%0d] got rd=%0d data=%h want rd=%0d data=%h", i, r, d, 5 + i, exp_t[i]);
      end
    end
  endtask

  task automatic test_misalign;
    int lat, n_re, n_we; logic rdy, busy, mis; logic [31:0] wa, wdv, d; logic [4:0] r;
    do_req(1'b0, 3'd2, 32'h13, 32'h0, 5'd9, lat, rdy, busy, n_re, n_we, wa, wdv, r, d, mis);
`ifdef LSU_MISALIGN_TRAP_EN
    checks++;
    if (lat != 1 || n_re != 0 || n_we != 0 || mis !== 1'b1 || r !== 5'd0 || d !== 32'd0) begin
      errors++; $display("FAIL misalign_trap got lat=%0d re=%0d we=%0d mis=%0b rd=%0d d=%h want 1 0 0 1 0 0", lat, n_re, n_we, mis, r, d);
    end
`else
    checks++;
    if (lat != 2 || n_re != 1 || mis !== 1'b0 || r !== 5'd9 || d !== 32'h8899_AABB) begin
      errors++; $display("FAIL misalign_ignored got lat=%0d re=%0d mis=%0b rd=%0d d=%h want 2 1 0 9 8899aabb", lat, n_re, mis, r, d);
    end
`endif
  endtask

  task automatic test_stores;
    int lat, n_re, n_we; logic rdy, busy, mis; logic [31:0] wa, wdv, d; logic [4:0] r;
    do_req(1'b1, 3'd0, 32'h12, 32'h1234_5655, 5'd3, lat, rdy, busy, n_re, n_we, wa, wdv, r, d, mis);
    mdl[4] = 32'h8855_AABB;
    checks++;
    if (lat != 3 || n_re != 1 || n_we != 1 || r !== 5'd0 || d !== 32'd0) begin
      errors++; $display("FAIL sb_seq got lat=%0d re=%0d we=%0d rd=%0d d=%h want 3 1 1 0 0", lat, n_re, n_we, r, d);
    end
    checks++;
    if (wa !== 32'd4 || wdv !== 32'h8855_AABB) begin
      errors++; $display("FAIL sb_write got addr=%0d data=%h want 4 8855aabb", wa, wdv);
    end
    do_req(1'b1, 3'd2, 32'h20, 32'hDEAD_BEEF, 5'd3, lat, rdy, busy, n_re, n_we, wa, wdv, r, d, mis);
    mdl[8] = 32'hDEAD_BEEF;
    checks++;
    if (lat != 2 || n_re != 0 || n_we != 1 || wa !== 32'd8 || wdv !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL sw_seq got lat=%0d re=%0d we=%0d addr=%0d data=%h want 2 0 1 8 deadbeef", lat, n_re, n_we, wa, wdv);
    end
    do_req(1'b0, 3'd2, 32'h20, 32'h0, 5'd12, lat, rdy, busy, n_re, n_we, wa, wdv, r, d, mis);
    checks++;
    if (lat != 2 || r !== 5'd12 || d !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL lw_after_sw got lat=%0d rd=%0d d=%h want 2 12 deadbeef", lat, r, d);
    end
  endtask

  task automatic test_unsupported;
    int lat, n_re, n_we; logic rdy, busy, mis; logic [31:0] wa, wdv, d; logic [4:0] r;
    do_req(1'b0, 3'd3, 32'h4, 32'h0, 5'd7, lat, rdy, busy, n_re, n_we, wa, wdv, r, d, mis);
    checks++;
    if (lat != 1 || n_re != 0 || n_we != 0 || r !== 5'd0 || d !== 32'd0 || mis !== 1'b0) begin
      errors++; $display("FAIL unsup_load got lat=%0d re=%0d we=%0d rd=%0d d=%h mis=%0b want 1 0 0 0 0 0", lat, n_re, n_we, r, d, mis);
    end
    do_req(1'b1, 3'd5, 32'h8, 32'hFFFF_FFFF, 5'd7, lat, rdy, busy, n_re, n_we, wa, wdv, r, d, mis);
    checks++;
    if (lat != 1 || n_re != 0 || n_we != 0 || r !== 5'd0 || d !== 32'd0) begin
      errors++; $display("FAIL unsup_store got lat=%0d re=%0d we=%0d rd=%0d d=%h want 1 0 0 0 0", lat, n_re, n_we, r, d);
    end
  endtask

  task automatic test_reset_mid_write;
    int seen_wb = 0;
    @(negedge clk);
    reqValid = 1'b1; reqWrite = 1'b1; reqFunct3 = 3'd1; reqAddr = 32'h10; reqWdata = $urandom; reqRd = 5'd0;
    @(posedge clk); #1; reqValid = 1'b0;
    @(negedge clk);
    checks++;
    if (dataCacheReadEnable !== 1'b1) begin
      errors++; $display("FAIL rmw_read_phase got re=%0b want 1", dataCacheReadEnable);
    end
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    checks++;
    if (dataCacheWriteEnable !== 1'b0) begin
      errors++; $display("FAIL rst_gates_write got we=%0b want 0", dataCacheWriteEnable);
    end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    checks++;
    if (reqReady !== 1'b1 || stall !== 1'b0) begin
      errors++; $display("FAIL rst_mid_ready got ready=%0b stall=%0b want 1 0", reqReady, stall);
    end
    for (int i = 0; i < 3; i++) begin
      if (wbValid === 1'b1) seen_wb++;
      @(negedge clk);
    end
    checks++;
    if (seen_wb != 0) begin
      errors++; $display("FAIL rst_mid_no_wb got %0d pulses want 0", seen_wb);
    end
    checks++;
    if (ram[4] !== mdl[4]) begin
      errors++; $display("FAIL rst_mid_ram got %h want %h", ram[4], mdl[4]);
    end
  endtask

  task automatic test_random;
    int lat, n_re, n_we, e_lat, e_re, e_we; logic rdy, busy, mis, e_mis, w, sup, bad;
    logic [31:0] wa, wdv, d, a, wd, e_d, e_word; logic [4:0] r, rd, e_rd; logic [2:0] f;
    for (int t = 0; t < 60; t++) begin
      w = 1'($urandom % 2);
      f = 3'($urandom_range(0, 7));
      a = 32'($urandom_range(0, 255));
      wd = $urandom;
      rd = 5'($urandom_range(1, 31));
      sup = ref_supported(w, f);
      bad = sup && ref_misaligned(f, a);
      e_mis = bad; e_rd = 5'd0; e_d = 32'd0; e_re = 0; e_we = 0; e_word = '0;
      if (!sup || bad) e_lat = 1;
      else if (!w) begin
        e_lat = 2; e_re = 1; e_rd = rd; e_d = ref_load(mdl[a / 4], f, a);
      end else begin
        e_lat = (f == 3'd2) ? 2 : 3; e_re = (f == 3'd2) ? 0 : 1; e_we = 1;
        e_word = ref_store(mdl[a / 4], f, a, wd);
        mdl[a / 4] = e_word;
      end
      do_req(w, f, a, wd, rd, lat, rdy, busy, n_re, n_we, wa, wdv, r, d, mis);
      checks++;
      if (lat != e_lat || n_re != e_re || n_we != e_we || !rdy || !busy) begin
        errors++; $display("FAIL rand_seq[%0d] w=%0b f=%0d a=%h got lat=%0d re=%0d we=%0d rdy=%0b busy=%0b want %0d %0d %0d 1 1",
                           t, w, f, a, lat, n_re, n_we, rdy, busy, e_lat, e_re, e_we);
      end
      checks++;
      if (r !== e_rd || d !== e_d || mis !== e_mis) begin
        errors++; $display("FAIL rand_wb[%0d] w=%0b f=%0d a=%h got rd=%0d d=%h mis=%0b want rd=%0d d=%h mis=%0b",
                           t, w, f, a, r, d, mis, e_rd, e_d, e_mis);
      end
      if (e_we == 1) begin
        checks++;
        if (wa !== a / 4 || wdv !== e_word) begin
          errors++; $display("FAIL rand_write[%0d] f=%0d a=%h got addr=%0d data=%h want %0d %h", t, f, a, wa, wdv, a / 4, e_word);
        end
      end
    end
  endtask

  task automatic test_memory;
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (ram[i] !== mdl[i]) begin
        errors++; $display("FAIL mem_word[%0d] got %h want %h", i, ram[i], mdl[i]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      init_img[i] = $urandom;
      mdl[i] = init_img[i];
    end
    init_img[4] = 32'h8899_AABB;
    mdl[4]      = 32'h8899_AABB;
    test_reset();
    test_loads();
    test_misalign();
    test_stores();
    test_unsupported();
    test_reset_mid_write();
    test_random();
    test_memory();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have a single clock, clk; reset, rst, SHALL be synchronous and active-high.
REQ-002 clk  input  1  system clock, all state on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 reqValid  input  1  ALU_MEM presents a memory request.
REQ-005 reqReady  output  1  unit idle and accepting; request accepted on edge with reqValid&reqReady.
REQ-006 reqWrite  input  1  1=store, 0=load.
REQ-007 reqFunct3  input  3  RV32I funct3 (LB/LH/LW/LBU/LHU; SB/SH/SW).
REQ-008 reqAddr  input  32  byte address.
REQ-009 reqWdata  input  32  store data (low byte/half used for SB/SH).
REQ-010 reqRd  input  5  load destination register.
REQ-011 dataCacheReadEnable / dataCacheWriteEnable  output  1 each  driven to the DataCacheReadAccept / DataCacheWriteAccept values when active, opposite value otherwise.
REQ-012 addr  output  32  word index into data RAM = latched byte address >> 2.
REQ-013 dataWrite  output  32  full word written to RAM.
REQ-014 dataRead  input  32  combinational RAM read word, valid same cycle as read enable.
REQ-015 wbValid  output  1  one-cycle result pulse to MEM_WB.
REQ-016 wbRd / wbData  output  5 / 32  writeback register and data.
REQ-017 stall  output  1  high whenever state != IDLE.
REQ-018 misalignErr  output  1  misaligned-access flag (see Configuration).

Function
REQ-019 FSM states SHALL be IDLE, READ, WRITE, RESP; reqReady=1 only in IDLE.
REQ-020 On acceptance, address, funct3, write flag, wdata, rd SHALL be latched; later input changes ignored.
REQ-021 Transitions: load -> READ -> RESP; SW -> WRITE -> RESP; SB/SH -> READ -> WRITE -> RESP (read-modify-write); RESP -> IDLE.
REQ-022 Latency from acceptance edge to wbValid: loads and SW 2 cycles, SB/SH 3 cycles; next request accepted earliest in the IDLE cycle after RESP.
REQ-023 READ SHALL assert read enable only; WRITE SHALL assert write enable only; both enables low in IDLE and RESP.
REQ-024 READ SHALL register dataRead at the end of the cycle.
REQ-025 Byte lane selection SHALL be little-endian: byte = addr[1:0], half = addr[1].
REQ-026 LB/LH SHALL sign-extend; LBU/LHU SHALL zero-extend; LW passes the word.
REQ-027 SB/SH SHALL merge the new byte/half into the registered read word at the selected lane, preserving other lanes.
REQ-028 In RESP, wbValid=1; loads: wbRd=latched rd, wbData=extended value; stores: wbRd=0, wbData=0.
REQ-029 Unsupported funct3 (load 011/110/111, store 011-111) SHALL go IDLE -> RESP with no enable asserted, wbRd=0, wbData=0.
REQ-030 reqValid outside IDLE SHALL be ignored (no queueing).

Reset
REQ-031 On rst edge: state=IDLE; wbValid=0, wbRd=0, wbData=0, misalignErr=0, latched registers=0; reqReady=1 and stall=0 the following cycle.
REQ-032 While rst is high, both enables SHALL be forced inactive combinationally, so a reset during WRITE performs no RAM write.
REQ-033 Reset mid-operation SHALL abandon the request with no wbValid pulse.

Configuration
REQ-034 Macro LSU_MISALIGN_TRAP_EN defined: LH/LHU/SH with addr[0]=1 or LW/SW with addr[1:0]!=0 SHALL go IDLE -> RESP with no RAM access, misalignErr=1 for the RESP cycle only, wbRd=0, wbData=0.
REQ-035 Macro undefined: misalignErr tied 0; half accesses ignore addr[0]; word accesses ignore addr[1:0].

Verification
REQ-036 RAM word 4=0x8899AABB; LB addr 0x11 rd=5 -> READ one cycle, wbValid 2 cycles after accept, wbRd=5, wbData=0xFFFFFFAA.
REQ-037 Same RAM; LBU 0x11 -> 0x000000AA; LH 0x12 -> 0xFFFF8899; LHU 0x12 -> 0x00008899.
REQ-038 SB addr 0x12 wdata 0x12345655 -> READ, WRITE with addr=4 dataWrite=0x8855AABB, wbValid with wbRd=0 at cycle 3.
REQ-039 SW addr 0x20 wdata 0xDEADBEEF -> no read enable, one write cycle addr=8, then LW 0x20 returns 0xDEADBEEF.
REQ-040 With LSU_MISALIGN_TRAP_EN, LW addr 0x13 -> no enable ever asserted, misalignErr=1 one cycle later with wbValid; without macro, same LW reads word 4.
REQ-041 SH to 0x10, rst asserted during WRITE cycle -> no write enable seen, RAM word unchanged, no wbValid, reqReady=1 cycle after reset released.
